// File: rtl/tsmem_arbiter.sv
// tsmem_arbiter: shares the timestamp SRAM between the event path, a host port and a zero-fill engine.
// Define CLEAR_ON_RESET_EN to start a zero-fill sweep directly out of reset.
module tsmem_arbiter #(
  parameter int DVS_WIDTH  = 346,
  parameter int DVS_HEIGHT = 260,
  parameter int WORD_SIZE  = 18,
  parameter int STARVE_MAX = 8,
  parameter int TAG_DEPTH  = 4,
  localparam int W_ADDR    = $clog2(DVS_WIDTH * DVS_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 evt_req,
  input  logic                 evt_rw,
  input  logic [W_ADDR-1:0]    evt_addr1,
  input  logic [W_ADDR-1:0]    evt_addr2,
  input  logic [WORD_SIZE-1:0] evt_wdata,
  output logic                 evt_gnt,
  output logic                 evt_rd_vld1,
  output logic                 evt_rd_vld2,
  input  logic                 host_req,
  input  logic                 host_rw,
  input  logic [W_ADDR-1:0]    host_addr,
  input  logic [WORD_SIZE-1:0] host_wdata,
  output logic                 host_gnt,
  output logic [WORD_SIZE-1:0] host_rdata,
  output logic                 host_rdata_vld,
  input  logic                 clear_start,
  output logic                 clear_busy,
  input  logic                 read_data_mem_vld1,
  input  logic                 read_data_mem_vld2,
  input  logic [WORD_SIZE-1:0] read_data1_mem,
  output logic [WORD_SIZE-1:0] write_data_mem,
  output logic                 rw,
  output logic                 cen,
  output logic [W_ADDR-1:0]    addr_port1,
  output logic [W_ADDR-1:0]    addr_port2
);

  localparam int NUM_WORDS = DVS_WIDTH * DVS_HEIGHT;
  localparam int SW        = $clog2(STARVE_MAX + 1);
  localparam int PW        = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW        = $clog2(TAG_DEPTH + 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [CW-1:0]     TAG_FULL   = CW'(TAG_DEPTH);
  localparam logic [W_ADDR-1:0] LAST_ADDR  = W_ADDR'(NUM_WORDS - 1);
  localparam logic              TAG_EVT    = 1'b0;
  localparam logic              TAG_HOST   = 1'b1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state_q, state_d;
  logic [W_ADDR-1:0]     clear_addr_q, clear_addr_d;
  logic                  clear_pend_q, clear_pend_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  cen_q, cen_d;
  logic                  rw_q, rw_d;
  logic [W_ADDR-1:0]     addr1_q, addr1_d;
  logic [W_ADDR-1:0]     addr2_q, addr2_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic [TAG_DEPTH-1:0]  tag_q, tag_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic fifo_empty, fifo_full, head_tag, pop, push, push_tag;
  logic evt_ok, host_ok, host_first;

  // Read returns are steered by the owner tag at the FIFO head; returns with no owner are dropped.
  always_comb begin
    fifo_empty     = (cnt_q == '0);
    fifo_full      = (cnt_q == TAG_FULL);
    head_tag       = tag_q[rd_ptr_q];
    pop            = read_data_mem_vld1 && !fifo_empty;
    evt_rd_vld1    = pop && (head_tag == TAG_EVT);
    evt_rd_vld2    = read_data_mem_vld2 && !fifo_empty && (head_tag == TAG_EVT);
    host_rdata_vld = pop && (head_tag == TAG_HOST);
    host_rdata     = read_data1_mem;
  end

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    clear_pend_d = clear_pend_q;
    starve_d     = starve_q;
    cen_d        = 1'b1;
    rw_d         = rw_q;
    addr1_d      = addr1_q;
    addr2_d      = addr2_q;
    wdata_d      = wdata_q;
    evt_gnt      = 1'b0;
    host_gnt     = 1'b0;
    push         = 1'b0;
    push_tag     = TAG_EVT;
    evt_ok       = evt_req && (evt_rw || !fifo_full);
    host_ok      = host_req && (host_rw || !fifo_full);
    host_first   = host_req && (starve_q == STARVE_LIM);

    case (state_q)
      IDLE: begin
        if (host_first && host_ok) host_gnt = 1'b1;
        else if (evt_ok)           evt_gnt  = 1'b1;
        else if (host_ok)          host_gnt = 1'b1;

        if (evt_gnt) begin
          cen_d    = 1'b0;
          rw_d     = evt_rw;
          addr1_d  = evt_addr1;
          addr2_d  = evt_addr2;
          wdata_d  = evt_wdata;
          push     = !evt_rw;
          push_tag = TAG_EVT;
        end else if (host_gnt) begin
          cen_d    = 1'b0;
          rw_d     = host_rw;
          addr1_d  = host_addr;
          addr2_d  = '0;
          wdata_d  = host_wdata;
          push     = !host_rw;
          push_tag = TAG_HOST;
        end

        if (!host_req || host_gnt)                   starve_d = '0;
        else if (evt_gnt && (starve_q != STARVE_LIM)) starve_d = starve_q + SW'(1);

        // The sweep must not start while reads are in flight, so the request waits for a drained FIFO.
        if (clear_start || clear_pend_q) begin
          if (fifo_empty) begin
            state_d      = CLEAR;
            clear_addr_d = '0;
            clear_pend_d = 1'b0;
          end else begin
            clear_pend_d = 1'b1;
          end
        end
      end

      CLEAR: begin
        cen_d   = 1'b0;
        rw_d    = 1'b1;
        addr1_d = clear_addr_q;
        addr2_d = '0;
        wdata_d = '0;
        if (!host_req) starve_d = '0;
        if (clear_addr_q == LAST_ADDR) state_d = IDLE;
        else                           clear_addr_d = clear_addr_q + W_ADDR'(1);
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      tag_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef CLEAR_ON_RESET_EN
      state_q <= CLEAR;
`else
      state_q <= IDLE;
`endif
      clear_addr_q <= '0;
      clear_pend_q <= 1'b0;
      starve_q     <= '0;
      cen_q        <= 1'b1;
      rw_q         <= 1'b0;
      addr1_q      <= '0;
      addr2_q      <= '0;
      wdata_q      <= '0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      clear_pend_q <= clear_pend_d;
      starve_q     <= starve_d;
      cen_q        <= cen_d;
      rw_q         <= rw_d;
      addr1_q      <= addr1_d;
      addr2_q      <= addr2_d;
      wdata_q      <= wdata_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign clear_busy     = (state_q == CLEAR);
  assign cen            = cen_q;
  assign rw             = rw_q;
  assign addr_port1     = addr1_q;
  assign addr_port2     = addr2_q;
  assign write_data_mem = wdata_q;

endmodule

// File: tb/tb_tsmem_arbiter.sv
// tb_tsmem_arbiter: directed stimulus for tsmem_arbiter with a queue-based reference model
// checked every cycle, plus hand-computed expectations at key points.
module tb_tsmem_arbiter;

  localparam int W_ADDR = 17;
  localparam int WS     = 18;
  localparam int N_PIX  = 346 * 260;
  localparam int STARVE = 8;
  localparam int TDEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              evt_req = 1'b0, evt_rw = 1'b0;
  logic [W_ADDR-1:0] evt_addr1 = '0, evt_addr2 = '0;
  logic [WS-1:0]     evt_wdata = '0;
  logic              host_req = 1'b0, host_rw = 1'b0;
  logic [W_ADDR-1:0] host_addr = '0;
  logic [WS-1:0]     host_wdata = '0;
  logic              clear_start = 1'b0;
  logic              read_data_mem_vld1 = 1'b0, read_data_mem_vld2 = 1'b0;
  logic [WS-1:0]     read_data1_mem = '0;

  logic              evt_gnt, evt_rd_vld1, evt_rd_vld2;
  logic              host_gnt, host_rdata_vld, clear_busy;
  logic [WS-1:0]     host_rdata, write_data_mem;
  logic              rw, cen;
  logic [W_ADDR-1:0] addr_port1, addr_port2;

  tsmem_arbiter dut (
    .clk(clk), .rst(rst),
    .evt_req(evt_req), .evt_rw(evt_rw), .evt_addr1(evt_addr1), .evt_addr2(evt_addr2),
    .evt_wdata(evt_wdata), .evt_gnt(evt_gnt), .evt_rd_vld1(evt_rd_vld1), .evt_rd_vld2(evt_rd_vld2),
    .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rdata_vld(host_rdata_vld),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .read_data_mem_vld1(read_data_mem_vld1), .read_data_mem_vld2(read_data_mem_vld2),
    .read_data1_mem(read_data1_mem), .write_data_mem(write_data_mem),
    .rw(rw), .cen(cen), .addr_port1(addr_port1), .addr_port2(addr_port2)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic er, input logic erw, input int ea1, input int ea2,
                               input int ewd, input logic hr, input logic hrw, input int ha,
                               input int hwd);
    evt_req    = er;
    evt_rw     = erw;
    evt_addr1  = W_ADDR'(ea1);
    evt_addr2  = W_ADDR'(ea2);
    evt_wdata  = WS'(ewd);
    host_req   = hr;
    host_rw    = hrw;
    host_addr  = W_ADDR'(ha);
    host_wdata = WS'(hwd);
  endtask

  // Reference model: owners of outstanding reads in a queue, counters for starvation and sweep.
  bit m_clear, m_pend;
  int m_caddr, m_starve;
  int tagq[$];
  bit e_cen = 1'b1, e_rw;
  int e_a1, e_a2, e_wd;

  initial begin
    int sz, head;
    bit full, ecan, hcan, eg, hg;
    forever begin
      @(negedge clk);
      cyc++;
      sz   = tagq.size();
      full = (sz >= TDEPTH);
      eg   = 1'b0;
      hg   = 1'b0;
      if (!m_clear) begin
        ecan = evt_req && (evt_rw || !full);
        hcan = host_req && (host_rw || !full);
        if (hcan && m_starve == STARVE) hg = 1'b1;
        else if (ecan)                  eg = 1'b1;
        else if (hcan)                  hg = 1'b1;
      end
      head = (sz > 0) ? tagq[0] : -1;

      if (chk_en) begin
        checkOutput("model_evt_gnt", 32'(evt_gnt), 32'(eg));
        checkOutput("model_host_gnt", 32'(host_gnt), 32'(hg));
        checkOutput("model_clear_busy", 32'(clear_busy), 32'(m_clear));
        checkOutput("model_evt_rd_vld1", 32'(evt_rd_vld1), 32'(read_data_mem_vld1 && head == 0));
        checkOutput("model_evt_rd_vld2", 32'(evt_rd_vld2), 32'(read_data_mem_vld2 && head == 0));
        checkOutput("model_host_rdata_vld", 32'(host_rdata_vld), 32'(read_data_mem_vld1 && head == 1));
        if (read_data_mem_vld1 && head == 1)
          checkOutput("model_host_rdata", 32'(host_rdata), 32'(read_data1_mem));
        checkOutput("model_cen", 32'(cen), 32'(e_cen));
        if (!e_cen) begin
          checkOutput("model_rw", 32'(rw), 32'(e_rw));
          checkOutput("model_addr_port1", 32'(addr_port1), e_a1);
          checkOutput("model_addr_port2", 32'(addr_port2), e_a2);
          checkOutput("model_write_data", 32'(write_data_mem), e_wd);
        end
      end

      if (rst) begin
`ifdef CLEAR_ON_RESET_EN
        m_clear = 1'b1;
`else
        m_clear = 1'b0;
`endif
        m_pend   = 1'b0;
        m_caddr  = 0;
        m_starve = 0;
        e_cen    = 1'b1;
        tagq.delete();
      end else begin
        if (m_clear) begin
          e_cen = 1'b0; e_rw = 1'b1; e_a1 = m_caddr; e_a2 = 0; e_wd = 0;
        end else if (eg) begin
          e_cen = 1'b0; e_rw = evt_rw; e_a1 = int'(evt_addr1); e_a2 = int'(evt_addr2);
          e_wd = int'(evt_wdata);
        end else if (hg) begin
          e_cen = 1'b0; e_rw = host_rw; e_a1 = int'(host_addr); e_a2 = 0; e_wd = int'(host_wdata);
        end else begin
          e_cen = 1'b1;
        end

        if (read_data_mem_vld1 && sz > 0) void'(tagq.pop_front());
        if (eg && !evt_rw)  tagq.push_back(0);
        if (hg && !host_rw) tagq.push_back(1);

        if (!host_req || hg)             m_starve = 0;
        else if (eg && m_starve < STARVE) m_starve++;

        if (m_clear) begin
          if (m_caddr == N_PIX - 1) m_clear = 1'b0;
          else                      m_caddr++;
        end else if (clear_start || m_pend) begin
          if (sz == 0) begin
            m_clear = 1'b1;
            m_caddr = 0;
            m_pend  = 1'b0;
          end else begin
            m_pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int evt_cnt, host_cnt, host_at, grants, busy_cycles, k;
    logic [9:0] gpat;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_cen", 32'(cen), 32'd1);
    checkOutput("reset_rw", 32'(rw), 32'd0);
    checkOutput("reset_addr1", 32'(addr_port1), 32'd0);
    checkOutput("reset_addr2", 32'(addr_port2), 32'd0);
    checkOutput("reset_wdata", 32'(write_data_mem), 32'd0);
    checkOutput("reset_evt_gnt", 32'(evt_gnt), 32'd0);
    checkOutput("reset_host_vld", 32'(host_rdata_vld), 32'd0);
`ifdef CLEAR_ON_RESET_EN
    checkOutput("reset_clear_busy", 32'(clear_busy), 32'd1);
`else
    checkOutput("reset_clear_busy", 32'(clear_busy), 32'd0);
`endif
    nextCycle();
    rst    = 1'b0;
    chk_en = 1'b1;

`ifdef CLEAR_ON_RESET_EN
    busy_cycles = 0;
    k = 0;
    while (k < 95000) begin
      @(negedge clk);
      if (!clear_busy) break;
      busy_cycles++;
      nextCycle();
      k++;
    end
    checkOutput("por_clear_length", 32'(busy_cycles), 32'(N_PIX));
    nextCycle();
`endif

    // Event write
    applyStimulus(1, 1, 1000, 2000, 'h155, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_evt_gnt", 32'(evt_gnt), 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_cen", 32'(cen), 32'd0);
    checkOutput("t1_rw", 32'(rw), 32'd1);
    checkOutput("t1_addr1", 32'(addr_port1), 32'd1000);
    checkOutput("t1_addr2", 32'(addr_port2), 32'd2000);
    checkOutput("t1_wdata", 32'(write_data_mem), 32'h155);
    nextCycle();

    // Starvation limit
    applyStimulus(1, 1, 40, 41, 'h11, 1, 1, 7, 'h3);
    evt_cnt = 0; host_cnt = 0; host_at = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (evt_gnt) evt_cnt++;
      if (host_gnt) begin
        host_cnt++;
        if (host_at < 0) host_at = i;
      end
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_evt_grants", 32'(evt_cnt), 32'd11);
    checkOutput("t2_host_grants", 32'(host_cnt), 32'd1);
    checkOutput("t2_host_slot", 32'(host_at), 32'd8);

    // Host read with return two cycles after issue
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 5, 0);
    @(negedge clk);
    checkOutput("t3_host_gnt", 32'(host_gnt), 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t3_rw", 32'(rw), 32'd0);
    checkOutput("t3_addr1", 32'(addr_port1), 32'd5);
    checkOutput("t3_addr2", 32'(addr_port2), 32'd0);
    nextCycle();
    nextCycle();
    read_data_mem_vld1 = 1'b1; read_data_mem_vld2 = 1'b1; read_data1_mem = 18'h2AA;
    @(negedge clk);
    checkOutput("t3_host_vld", 32'(host_rdata_vld), 32'd1);
    checkOutput("t3_host_rdata", 32'(host_rdata), 32'h2AA);
    checkOutput("t3_evt_vld1", 32'(evt_rd_vld1), 32'd0);
    checkOutput("t3_evt_vld2", 32'(evt_rd_vld2), 32'd0);
    nextCycle();
    read_data_mem_vld1 = 1'b0; read_data_mem_vld2 = 1'b0;

    // Back-to-back event reads fill the tag FIFO
    evt_req = 1'b1; evt_rw = 1'b0; grants = 0; gpat = '0;
    for (int i = 0; i < 10; i++) begin
      evt_addr1 = W_ADDR'(100 + grants);
      evt_addr2 = W_ADDR'(200 + grants);
      read_data_mem_vld1 = (i == 7);
      read_data_mem_vld2 = (i == 7);
      read_data1_mem     = 18'h111;
      @(negedge clk);
      gpat[i] = evt_gnt;
      if (evt_gnt) grants++;
      if (i == 7) begin
        checkOutput("t4_evt_vld1", 32'(evt_rd_vld1), 32'd1);
        checkOutput("t4_evt_vld2", 32'(evt_rd_vld2), 32'd1);
        checkOutput("t4_host_vld", 32'(host_rdata_vld), 32'd0);
      end
      nextCycle();
    end
    evt_req = 1'b0;
    read_data_mem_vld1 = 1'b0; read_data_mem_vld2 = 1'b0;
    checkOutput("t4_gnt_pattern", 32'(gpat), 32'h10F);
    checkOutput("t4_total_grants", 32'(grants), 32'd5);
    for (int i = 0; i < 4; i++) begin
      read_data_mem_vld1 = 1'b1;
      read_data_mem_vld2 = (i % 2 == 0);
      @(negedge clk);
      checkOutput("t4_drain_vld1", 32'(evt_rd_vld1), 32'd1);
      nextCycle();
    end
    read_data_mem_vld1 = 1'b1; read_data_mem_vld2 = 1'b1;
    @(negedge clk);
    checkOutput("t4_empty_evt_vld1", 32'(evt_rd_vld1), 32'd0);
    checkOutput("t4_empty_evt_vld2", 32'(evt_rd_vld2), 32'd0);
    checkOutput("t4_empty_host_vld", 32'(host_rdata_vld), 32'd0);
    nextCycle();
    read_data_mem_vld1 = 1'b0; read_data_mem_vld2 = 1'b0;

`ifndef CLEAR_ON_RESET_EN
    // Clear request held while a read is outstanding, then the full sweep
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 9, 0);
    @(negedge clk);
    checkOutput("t5_host_gnt", 32'(host_gnt), 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_start = 1'b1;
    nextCycle();
    clear_start = 1'b0;
    @(negedge clk);
    checkOutput("t5_pending_busy", 32'(clear_busy), 32'd0);
    nextCycle();
    read_data_mem_vld1 = 1'b1; read_data1_mem = 18'h0AB;
    @(negedge clk);
    checkOutput("t5_host_vld", 32'(host_rdata_vld), 32'd1);
    nextCycle();
    read_data_mem_vld1 = 1'b0;
    @(negedge clk);
    checkOutput("t5_drained_busy", 32'(clear_busy), 32'd0);
    nextCycle();
    applyStimulus(1, 1, 60, 61, 'h5, 1, 1, 62, 'h6);
    @(negedge clk);
    checkOutput("t5_clear_entered", 32'(clear_busy), 32'd1);
    busy_cycles = 1;
    k = 0;
    while (k < 95000) begin
      nextCycle();
      clear_start = (busy_cycles == 1000);
      @(negedge clk);
      if (!clear_busy) break;
      busy_cycles++;
      k++;
    end
    clear_start = 1'b0;
    checkOutput("t5_clear_length", 32'(busy_cycles), 32'(N_PIX));
    checkOutput("t5_last_cen", 32'(cen), 32'd0);
    checkOutput("t5_last_rw", 32'(rw), 32'd1);
    checkOutput("t5_last_addr", 32'(addr_port1), 32'(N_PIX - 1));
    checkOutput("t5_last_wdata", 32'(write_data_mem), 32'd0);
    checkOutput("t5_post_evt_gnt", 32'(evt_gnt), 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
`endif

    // Clear start together with a request, then reset partway through the sweep
    applyStimulus(1, 1, 50, 51, 'h7, 0, 0, 0, 0);
    clear_start = 1'b1;
    @(negedge clk);
    checkOutput("t6_evt_gnt", 32'(evt_gnt), 32'd1);
    checkOutput("t6_busy_same_cycle", 32'(clear_busy), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_start = 1'b0;
    @(negedge clk);
    checkOutput("t6_busy_next_cycle", 32'(clear_busy), 32'd1);
    for (int i = 0; i < 300; i++) nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_pin_addr_299", 32'(addr_port1), 32'd299);
    checkOutput("t6_pin_cen", 32'(cen), 32'd0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_reset_cen", 32'(cen), 32'd1);
`ifdef CLEAR_ON_RESET_EN
    checkOutput("t6_reset_busy", 32'(clear_busy), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("t6_restart_cen", 32'(cen), 32'd0);
    checkOutput("t6_restart_addr", 32'(addr_port1), 32'd0);
`else
    checkOutput("t6_reset_busy", 32'(clear_busy), 32'd0);
    nextCycle();
    applyStimulus(1, 1, 77, 78, 'h3C, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t6_idle_evt_gnt", 32'(evt_gnt), 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t6_idle_addr", 32'(addr_port1), 32'd77);
`endif
    nextCycle();
    nextCycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
